// File: rtl/modexp_sequencer_if.sv
// Job and sub-unit signal bundle for modexp_sequencer.
// The master drives jobs and answers square/multiply requests; the slave is the sequencer.
interface modexp_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             ready_in;
  logic [WIDTH-1:0] base_in;
  logic [WIDTH-1:0] exponent_in;
  logic [WIDTH-1:0] modulus_in;
  logic [WIDTH-1:0] result_out;
  logic             busy_out;
  logic             valid_out;

  logic             sq_ready_out;
  logic [WIDTH-1:0] sq_value_out;
  logic [WIDTH-1:0] sq_modulus_out;
  logic [WIDTH-1:0] sq_result_in;
  logic             sq_valid_in;

  logic             mul_ready_out;
  logic [WIDTH-1:0] mul_a_out;
  logic [WIDTH-1:0] mul_b_out;
  logic [WIDTH-1:0] mul_modulus_out;
  logic [WIDTH-1:0] mul_result_in;
  logic             mul_valid_in;

  modport master (
    output ready_in, base_in, exponent_in, modulus_in,
    output sq_result_in, sq_valid_in, mul_result_in, mul_valid_in,
    input  result_out, busy_out, valid_out,
    input  sq_ready_out, sq_value_out, sq_modulus_out,
    input  mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out
  );

  modport slave (
    input  ready_in, base_in, exponent_in, modulus_in,
    input  sq_result_in, sq_valid_in, mul_result_in, mul_valid_in,
    output result_out, busy_out, valid_out,
    output sq_ready_out, sq_value_out, sq_modulus_out,
    output mul_ready_out, mul_a_out, mul_b_out, mul_modulus_out
  );
endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving external square and multiply units.
// Define MODEXP_SKIP_LEADING_EN to skip leading zero exponent bits and the initial square of 1.
module modexp_sequencer #(
  parameter int WIDTH = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  modexp_sequencer_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, BIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, DONE
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   base_q, exp_q, mod_q, acc, result;
  logic [IDX_W-1:0]   idx;
  logic               busy, busy_d;
  logic               load_job, acc_from_sq, acc_from_mul, dec_idx, finish;
`ifdef MODEXP_SKIP_LEADING_EN
  logic               started;
  logic               set_started;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    load_job     = 1'b0;
    acc_from_sq  = 1'b0;
    acc_from_mul = 1'b0;
    dec_idx      = 1'b0;
    finish       = 1'b0;
`ifdef MODEXP_SKIP_LEADING_EN
    set_started  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.ready_in) begin
          load_job   = 1'b1;
          state_next = (bus.modulus_in < WIDTH'(2)) ? DONE : BIT;
        end
      end
      BIT: begin
`ifdef MODEXP_SKIP_LEADING_EN
        // Until the first set bit, acc stays 1 and squaring it is pointless.
        if (!started && !exp_q[idx]) begin
          if (idx == '0) state_next = DONE;
          else           dec_idx    = 1'b1;
        end else if (!started) begin
          set_started = 1'b1;
          state_next  = MUL_REQ;
        end else begin
          state_next = SQ_REQ;
        end
`else
        state_next = SQ_REQ;
`endif
      end
      SQ_REQ: state_next = SQ_WAIT;
      SQ_WAIT: begin
        if (bus.sq_valid_in) begin
          acc_from_sq = 1'b1;
          if (exp_q[idx])      state_next = MUL_REQ;
          else if (idx == '0)  state_next = DONE;
          else begin
            dec_idx    = 1'b1;
            state_next = BIT;
          end
        end
      end
      MUL_REQ: state_next = MUL_WAIT;
      MUL_WAIT: begin
        if (bus.mul_valid_in) begin
          acc_from_mul = 1'b1;
          if (idx == '0) state_next = DONE;
          else begin
            dec_idx    = 1'b1;
            state_next = BIT;
          end
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      acc    <= '0;
      result <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      busy_d <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_EN
      started <= 1'b0;
`endif
    end else begin
      busy_d <= busy;
      if (load_job) begin
        base_q <= bus.base_in;
        exp_q  <= bus.exponent_in;
        mod_q  <= bus.modulus_in;
        idx    <= IDX_W'(WIDTH - 1);
        acc    <= (bus.modulus_in < WIDTH'(2)) ? '0 : WIDTH'(1);
        busy   <= 1'b1;
`ifdef MODEXP_SKIP_LEADING_EN
        started <= 1'b0;
`endif
      end
`ifdef MODEXP_SKIP_LEADING_EN
      if (set_started) started <= 1'b1;
`endif
      if (acc_from_sq)  acc <= bus.sq_result_in;
      if (acc_from_mul) acc <= bus.mul_result_in;
      if (dec_idx)      idx <= idx - IDX_W'(1);
      if (finish) begin
        result <= acc;
        busy   <= 1'b0;
      end
    end
  end

  // acc, base_q and mod_q only change on job load or on an accepted valid,
  // so the request operands hold from request pulse to response.
  assign bus.result_out      = result;
  assign bus.busy_out        = busy;
  assign bus.valid_out       = busy_d & ~busy;
  assign bus.sq_ready_out    = (state == SQ_REQ);
  assign bus.sq_value_out    = acc;
  assign bus.sq_modulus_out  = mod_q;
  assign bus.mul_ready_out   = (state == MUL_REQ);
  assign bus.mul_a_out       = acc;
  assign bus.mul_b_out       = base_q;
  assign bus.mul_modulus_out = mod_q;
endmodule
